// File: rtl/bnn_pkg.sv
// Shared types and defaults for the binary-network vote accumulator.
// Holds the two-state controller encoding and the default sizing parameters.
package bnn_pkg;

    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_WINDOW      = 8;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    // Keeps a one-neuron configuration from collapsing the index to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_argmax.sv
// Combinational argmax over the per-neuron vote counters.
// Lowest index wins on equal counts; tie flags two or more neurons at the maximum.
module bnn_argmax
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int IDX_W      = idx_width(NUM_NEURONS),
    localparam int HIT_W      = $clog2(NUM_NEURONS + 1)
) (
    input  logic [NUM_NEURONS-1:0][CNT_W-1:0] votes,
    output logic [IDX_W-1:0]                  index,
    output logic [CNT_W-1:0]                  max_count,
    output logic                              tie
);

    logic [HIT_W-1:0] hits;

    // Strict greater-than keeps the earliest neuron when counts are equal.
    always_comb begin
        max_count = votes[0];
        index     = '0;
        for (int i = 1; i < NUM_NEURONS; i++) begin
            if (votes[i] > max_count) begin
                max_count = votes[i];
                index     = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            hits = hits + HIT_W'(votes[i] == max_count);
        end
        tie = (hits > HIT_W'(1));
    end

endmodule

// File: rtl/bnn_vote_accumulator.sv
// Accumulates binary neuron activations over a fixed window of samples and
// reports the neuron with the most votes through a ready/valid result port.
module bnn_vote_accumulator
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int IDX_W      = idx_width(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_NEURONS-1:0] in_act,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_class,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_tie,
    output logic                   busy
);

    if (WINDOW < 1 || WINDOW > (1 << CNT_W) - 1) begin : g_window_check
        $error("bnn_vote_accumulator: WINDOW must lie in 1..2**CNT_W-1");
    end

    state_t                           state;
    logic [NUM_NEURONS-1:0][CNT_W-1:0] votes;
    logic [NUM_NEURONS-1:0][CNT_W-1:0] votes_next;
    logic [CNT_W-1:0]                  sample_cnt;
    logic                              accept;
    logic                              last_sample;
    logic [IDX_W-1:0]                  win_index;
    logic [CNT_W-1:0]                  win_count;
    logic                              win_tie;

    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == REPORT);
    assign busy        = (sample_cnt != '0) || (state == REPORT);
    assign accept      = in_valid && in_ready && !clear;
    assign last_sample = (sample_cnt == CNT_W'(WINDOW - 1));

    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            votes_next[i] = votes[i] + CNT_W'(in_act[i]);
        end
    end

    // The winner is judged on the votes including the sample being accepted,
    // so the result can be captured on the same edge as the final sample.
    bnn_argmax #(
        .NUM_NEURONS (NUM_NEURONS),
        .CNT_W       (CNT_W)
    ) u_argmax (
        .votes     (votes_next),
        .index     (win_index),
        .max_count (win_count),
        .tie       (win_tie)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            votes      <= '0;
            sample_cnt <= '0;
            out_class  <= '0;
            out_count  <= '0;
            out_tie    <= 1'b0;
        end else if (clear) begin
            state      <= ACCUM;
            votes      <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        votes      <= votes_next;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (last_sample) begin
                            state     <= REPORT;
                            out_class <= win_index;
                            out_count <= win_count;
                            out_tie   <= win_tie;
                        end
                    end
                end
                REPORT: begin
                    // Result outputs hold until the consumer takes them.
                    if (out_ready) begin
                        state      <= ACCUM;
                        votes      <= '0;
                        sample_cnt <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Bench for bnn_vote_accumulator: window-level behavioural model compared every
// cycle, plus directed windows with hand-computed expected results.
module tb_bnn_vote_accumulator;

    localparam int NN  = 4;
    localparam int WIN = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_act = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_class;
    logic [3:0] out_count;
    logic       out_tie;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bnn_vote_accumulator #(.NUM_NEURONS(NN), .WINDOW(WIN), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .out_tie   (out_tie),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a window is a list of accepted samples; the result is
    // the plain argmax of per-neuron sums once WIN samples have been taken.
    int m_votes[NN];
    int m_taken;
    bit m_report;
    int m_class, m_count;
    bit m_tie;

    function automatic void model_zero();
        for (int i = 0; i < NN; i++) m_votes[i] = 0;
        m_taken = 0;
        m_report = 1'b0;
    endfunction

    function automatic void model_result();
        int best = 0;
        int n = 0;
        for (int i = 0; i < NN; i++) if (m_votes[i] > best) best = m_votes[i];
        m_class = -1;
        for (int i = 0; i < NN; i++) begin
            if (m_votes[i] == best) begin
                n++;
                if (m_class < 0) m_class = i;
            end
        end
        m_count = best;
        m_tie = (n >= 2);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_zero();
            m_class = 0; m_count = 0; m_tie = 1'b0;
        end else if (clear) begin
            model_zero();
        end else if (m_report) begin
            if (out_ready) model_zero();
        end else if (in_valid) begin
            for (int i = 0; i < NN; i++) m_votes[i] += int'(in_act[i]);
            m_taken++;
            if (m_taken == WIN) begin
                m_report = 1'b1;
                model_result();
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  in_ready,  !m_report);
        chk("out_valid", out_valid, m_report);
        chk("busy",      busy,      (m_taken != 0) || m_report);
        chk("out_class", out_class, m_class);
        chk("out_count", out_count, m_count);
        chk("out_tie",   out_tie,   m_tie);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_act = a;
            tick();
        end
        in_valid = 1'b0;
        in_act = '0;
    endtask

    task automatic expect_result(input string tag, input int c, input int cnt, input bit t);
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " class"}, out_class, c);
        chk({tag, " count"}, out_count, cnt);
        chk({tag, " tie"},   out_tie,   t);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after take in_ready", in_ready, 1);
        chk("after take busy", busy, 0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready",  in_ready,  1);
        chk("reset busy",      busy,      0);
        chk("reset class",     out_class, 0);
        chk("reset count",     out_count, 0);
        chk("reset tie",       out_tie,   0);

        // Single clean result pulse with out_ready held high.
        out_ready = 1'b1;
        feed(4'b0001, WIN);
        expect_result("w0001", 0, 8, 0);
        tick();
        chk("w0001 pulse ends", out_valid, 0);
        out_ready = 1'b0;

        feed(4'b1100, 5);
        feed(4'b0100, 3);
        expect_result("w1100", 2, 8, 0);
        chk("w1100 vote3", dut.votes[3], 5);
        take_result();

        feed(4'b1010, WIN);
        expect_result("w1010", 1, 8, 1);
        take_result();

        feed(4'b0000, WIN);
        expect_result("wzero", 0, 0, 1);

        // Producer keeps offering while the result is stalled.
        in_valid = 1'b1;
        in_act = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall in_ready", in_ready, 0);
            expect_result("stall", 0, 0, 1);
        end
        chk("stall vote0", dut.votes[0], 0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stall release in_ready", in_ready, 1);
        chk("stall release busy", busy, 0);

        feed(4'b1111, 4);
        clear = 1'b1;
        in_valid = 1'b1;
        in_act = 4'b1111;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear busy", busy, 0);
        feed(4'b1000, WIN);
        expect_result("post clear", 3, 8, 0);
        take_result();

        feed(4'b0010, WIN);
        chk("pre reset valid", out_valid, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset busy", busy, 0);
        tick();
        reset = 1'b0;
        feed(4'b0100, WIN);
        expect_result("post reset", 2, 8, 0);
        take_result();

        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_act    = 4'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bnn_vote_accumulator.md
BNN_VOTE_ACCUMULATOR -- requirements
Module: bnn_vote_accumulator

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: width of the neuron activation vector consumed per sample.
REQ-002 SHALL have parameter WINDOW, default 8: number of accepted samples per classification window; legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 4: vote counter width; elaboration SHALL fail if WINDOW > 2^CNT_W-1.
REQ-004 clk  input  1  clock; reset is asynchronous, active-high, named reset.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 clear  input  1  synchronous abort of the current window.
REQ-007 in_valid  input  1  in_act holds a valid sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_act  input  NUM_NEURONS  binary neuron outputs of the XNOR-popcount layer.
REQ-010 out_valid  output  1  classification result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_class  output  clog2(NUM_NEURONS)  index of the winning neuron.
REQ-013 out_count  output  CNT_W  vote count of the winner.
REQ-014 out_tie  output  1  more than one neuron shares the maximum count.
REQ-015 busy  output  1  at least one sample accepted in the current window, or result pending.

Function
REQ-016 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and REPORT (in_ready=0, out_valid=1).
REQ-017 Sample SHALL be accepted on a rising clk edge with in_valid && in_ready; each set bit i of in_act increments vote[i] by 1; the sample counter increments by 1.
REQ-018 In_valid while in REPORT SHALL be ignored (no vote change); the producer holds its data.
REQ-019 On acceptance of the WINDOW-th sample, the state SHALL go to REPORT at that same edge, with out_class/out_count/out_tie registered from the vote values including that sample; out_valid asserts on the next cycle (latency 1 cycle from last accept).
REQ-020 Argmax: winner = highest vote; ties resolve to the lowest index; out_tie = 1 when two or more votes equal the maximum, including all-zero votes (out_class=0, out_count=0, out_tie=1).
REQ-021 Result outputs SHALL stay stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready edge: all votes and sample counter SHALL be zeroed, state returns to ACCUM; in_ready=1 on the following cycle; no sample accepted in that handshake cycle.
REQ-023 Clear SHALL have priority over every other event: zero votes and sample counter, state ACCUM, out_valid=0 next cycle; a sample presented during clear SHALL be discarded.
REQ-024 Vote counters SHALL never wrap (guaranteed by REQ-003); sample counter wraps to 0 only via REQ-022/REQ-023.
REQ-025 busy SHALL equal (sample counter != 0) || state==REPORT.

Reset
REQ-026 Reset SHALL force state ACCUM, votes 0, sample counter 0, out_valid=0, out_class=0, out_count=0, out_tie=0, busy=0, in_ready=1 after deassertion.
REQ-027 Reset asserted mid-window or in REPORT SHALL discard all partial votes and any pending result.

Structure
REQ-028 Shared package bnn_pkg SHALL hold NUM_NEURONS, CNT_W defaults and the state type (ACCUM, REPORT).
REQ-029 Argmax SHALL be a combinational sub-module bnn_argmax (votes in; index, max count, tie out), instantiated once.

Verification
REQ-030 WINDOW=8, 8 samples in_act=4'b0001, out_ready=1 -> one out_valid pulse, out_class=0, out_count=8, out_tie=0.
REQ-031 Samples 4'b1100 x5, 4'b0100 x3 -> out_class=2, out_count=8, out_tie=0; vote[3]=5.
REQ-032 Samples 4'b1010 x8 -> out_class=1, out_count=8, out_tie=1; all-zero window -> class 0, count 0, tie 1.
REQ-033 Window complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no votes change; out_ready=1 -> next cycle in_ready=1, counts 0.
REQ-034 Clear after 4 samples, then 8 samples of 4'b1000 -> out_class=3, out_count=8 (pre-clear votes absent).
REQ-035 Reset asserted during REPORT -> out_valid=0 immediately, busy=0, next full window reports only post-reset samples.
